// File: rtl/buf_writer.sv
// Stages host command words in a 2-entry queue and writes them into a downstream
// 40-bit command FIFO, appending an end marker after programs that lack one.
module buf_writer #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] END_OPCODE = 8'hBF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [31:0] in_payload,
  input  logic        in_last,
  input  logic        abort,
  output logic        fifo_write,
  output logic [39:0] fifo_write_data,
  input  logic [31:0] fifo_data_count,
  output logic        busy,
  output logic        program_done,
  output logic [31:0] words_written
);

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] payload;
    logic        last;
  } entry_t;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] STREAM   = 2'd1;
  localparam logic [1:0] EMIT_END = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [1:0]  q_cnt, q_cnt_nxt;
  entry_t      q_head, q_tail, q_head_nxt, q_tail_nxt;
  entry_t      in_entry;
  logic        accept, dequeue, emit_marker, can_write, head_is_end;
  logic        wr_nxt, done_nxt, in_ready_nxt;
  logic [39:0] data_nxt;
  logic [33:0] fifo_used;

  assign in_entry = {in_opcode, in_payload, in_last};

  // A write already on the bus is not yet reflected in fifo_data_count.
  assign fifo_used   = {2'b00, fifo_data_count} + {33'd0, fifo_write};
  assign can_write   = fifo_used < 34'(FIFO_DEPTH);
  assign accept      = in_valid && in_ready && !abort;
  assign dequeue     = !abort && can_write && (q_cnt != 2'd0) && (state != EMIT_END);
  assign emit_marker = !abort && can_write && (state == EMIT_END);
  assign head_is_end = q_head.opcode == END_OPCODE;
  assign busy        = (q_cnt != 2'd0) || (state == EMIT_END);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    q_head_nxt = q_head;
    q_tail_nxt = q_tail;
    q_cnt_nxt  = q_cnt;
    if (abort) begin
      q_cnt_nxt = 2'd0;
    end else begin
      case ({accept, dequeue})
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q_head_nxt = in_entry;
          end else begin
            q_head_nxt = q_tail;
            q_tail_nxt = in_entry;
          end
        end
        2'b10: begin
          if (q_cnt == 2'd0) q_head_nxt = in_entry;
          else               q_tail_nxt = in_entry;
          q_cnt_nxt = q_cnt + 2'd1;
        end
        2'b01: begin
          q_head_nxt = q_tail;
          q_cnt_nxt  = q_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (emit_marker) begin
      state_nxt = (q_cnt_nxt != 2'd0) ? STREAM : IDLE;
    end else if (dequeue && q_head.last && !head_is_end) begin
      state_nxt = EMIT_END;
    end else if (state != EMIT_END) begin
      state_nxt = (q_cnt_nxt != 2'd0) ? STREAM : IDLE;
    end
  end

  always_comb begin
    wr_nxt       = dequeue || emit_marker;
    done_nxt     = emit_marker || (dequeue && q_head.last && head_is_end);
    data_nxt     = fifo_write_data;
    if (emit_marker)  data_nxt = {END_OPCODE, 32'h0};
    else if (dequeue) data_nxt = {q_head.opcode, q_head.payload};
    // Ready is registered, so it is derived from the state being loaded.
    in_ready_nxt = !abort && (q_cnt_nxt != 2'd2) && (state_nxt != EMIT_END);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      q_cnt           <= 2'd0;
      in_ready        <= 1'b0;
      fifo_write      <= 1'b0;
      fifo_write_data <= 40'h0;
      program_done    <= 1'b0;
      words_written   <= 32'd0;
    end else begin
      state           <= state_nxt;
      q_cnt           <= q_cnt_nxt;
      in_ready        <= in_ready_nxt;
      fifo_write      <= wr_nxt;
      fifo_write_data <= data_nxt;
      program_done    <= done_nxt;
      words_written   <= words_written + 32'(wr_nxt);
    end
  end

  // NOTE: queue storage is not reset; q_cnt alone decides which entries are valid.
  always_ff @(posedge clk) begin
    q_head <= q_head_nxt;
    q_tail <= q_tail_nxt;
  end

endmodule

// File: tb/tb_buf_writer.sv
// Randomized self-checking bench for buf_writer: a FIFO occupancy model plus an
// expected-word list built from the program rules (words in order, marker if needed).
module tb_buf_writer;

  localparam int         DEPTH  = 16;
  localparam logic [7:0] END_OP = 8'hBF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_opcode = 8'h0;
  logic [31:0] in_payload = 32'h0;
  logic        in_last = 1'b0;
  logic        abort = 1'b0;
  logic        fifo_write;
  logic [39:0] fifo_write_data;
  logic [31:0] fifo_data_count = 32'd0;
  logic        busy;
  logic        program_done;
  logic [31:0] words_written;

  buf_writer #(.FIFO_DEPTH(DEPTH), .END_OPCODE(END_OP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_payload(in_payload), .in_last(in_last),
    .abort(abort), .fifo_write(fifo_write), .fifo_write_data(fifo_write_data),
    .fifo_data_count(fifo_data_count), .busy(busy), .program_done(program_done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          timeouts = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  logic        prev_wr = 1'b0;
  int          drain_mode = 0;   // 0: none, 1: every cycle, 2: random
  logic [39:0] got_q[$];
  int          got_cyc[$];
  int          done_cyc[$];
  logic [39:0] exp_q[$];
  logic [31:0] ww0;

  // FIFO model: a write sampled at an edge shows up in the count after the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_wr) fifo_data_count = fifo_data_count + 32'd1;
    if (fifo_data_count != 0 && (drain_mode == 1 || (drain_mode == 2 && $urandom_range(0, 1) == 1)))
      fifo_data_count = fifo_data_count - 32'd1;
    prev_wr = (fifo_write === 1'b1);
    if (fifo_write === 1'b1) begin
      got_q.push_back(fifo_write_data);
      got_cyc.push_back(cyc);
    end
    if (program_done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  endtask

  task automatic model_accept(input logic [7:0] op, input logic [31:0] pl, input logic last);
    exp_q.push_back({op, pl});
    if (last) begin
      exp_done++;
      if (op != END_OP) exp_q.push_back({END_OP, 32'h0});
    end
  endtask

  task automatic clear_sb();
    got_q.delete(); got_cyc.delete(); done_cyc.delete(); exp_q.delete();
    done_cnt = 0; exp_done = 0; timeouts = 0;
    ww0 = words_written;
  endtask

  task automatic send_word(input logic [7:0] op, input logic [31:0] pl, input logic last);
    bit acc;
    bit ok = 0;
    in_valid = 1'b1; in_opcode = op; in_payload = pl; in_last = last;
    for (int i = 0; i < 500; i++) begin
      acc = (in_ready === 1'b1);
      step();
      if (acc) begin
        model_accept(op, pl, last);
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) timeouts++;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      quiet = (busy === 1'b0 && fifo_write === 1'b0) ? quiet + 1 : 0;
      if (quiet >= 3) begin ok = 1; break; end
    end
    if (!ok) timeouts++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (fifo_write !== 1'b0) $display("FAIL reset_fifo_write: got %b want 0", fifo_write); else pass_cnt++;
    total_cnt++; if (program_done !== 1'b0) $display("FAIL reset_done: got %b want 0", program_done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (fifo_write_data !== 40'h0) $display("FAIL reset_data: got %h want 0", fifo_write_data); else pass_cnt++;
    total_cnt++; if (words_written !== 32'd0) $display("FAIL reset_ww: got %0d want 0", words_written); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    clear_sb();
    drain_mode = 1;
    send_word(8'h80, 32'h0, 1'b1);
    wait_idle();
    total_cnt++; if (timeouts != 0) $display("FAIL single_timeout: got %0d want 0", timeouts); else pass_cnt++;
    total_cnt++; if (got_q.size() != 2) $display("FAIL single_count: got %0d want 2", got_q.size()); else pass_cnt++;
    if (got_q.size() == 2) begin
      total_cnt++; if (got_q[0] !== 40'h8000000000) $display("FAIL single_word: got %h want 8000000000", got_q[0]); else pass_cnt++;
      total_cnt++; if (got_q[1] !== 40'hBF00000000) $display("FAIL single_marker: got %h want bf00000000", got_q[1]); else pass_cnt++;
      total_cnt++; if (got_cyc[1] - got_cyc[0] != 1) $display("FAIL single_consecutive: got gap %0d want 1", got_cyc[1] - got_cyc[0]); else pass_cnt++;
      total_cnt++;
      if (done_cyc.size() != 1 || done_cyc[0] != got_cyc[1])
        $display("FAIL single_done_align: got %0d pulses want 1 with marker", done_cyc.size());
      else pass_cnt++;
    end
    total_cnt++; if (words_written !== 32'd2) $display("FAIL single_ww: got %0d want 2", words_written); else pass_cnt++;
  endtask

  task automatic test_program();
    clear_sb();
    drain_mode = 1;
    send_word(8'h80, 32'h0, 1'b0);
    send_word(8'h40, 32'h0, 1'b0);
    send_word(8'h83, 32'h1, 1'b0);
    send_word(8'hBF, 32'h0, 1'b1);
    wait_idle();
    total_cnt++; if (timeouts != 0) $display("FAIL program_timeout: got %0d want 0", timeouts); else pass_cnt++;
    total_cnt++; if (got_q.size() != 4) $display("FAIL program_count: got %0d want 4", got_q.size()); else pass_cnt++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL program_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL program_done: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (words_written - ww0 !== 32'd4) $display("FAIL program_ww: got %0d want 4", words_written - ww0); else pass_cnt++;
  endtask

  task automatic test_random_programs();
    logic [7:0] op;
    int len;
    clear_sb();
    drain_mode = 2;
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(1, 4);
      for (int w = 0; w < len; w++) begin
        op = 8'($urandom_range(0, 255));
        if (w == len - 1 && $urandom_range(0, 1) == 1) op = END_OP;
        repeat ($urandom_range(0, 2)) step();
        send_word(op, $urandom, w == len - 1);
      end
    end
    drain_mode = 1;
    wait_idle();
    total_cnt++; if (timeouts != 0) $display("FAIL random_timeout: got %0d want 0", timeouts); else pass_cnt++;
    total_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL random_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != exp_done) $display("FAIL random_done: got %0d want %0d", done_cnt, exp_done); else pass_cnt++;
    total_cnt++; if (words_written - ww0 !== 32'(exp_q.size())) $display("FAIL random_ww: got %0d want %0d", words_written - ww0, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    logic [7:0]  ops[3];
    logic [31:0] pls[3];
    bit acc;
    int k = 0;
    clear_sb();
    drain_mode = 0;
    fifo_data_count = 32'd16;
    foreach (ops[i]) begin ops[i] = 8'($urandom_range(0, 255)); pls[i] = $urandom; end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_opcode = ops[k]; in_payload = pls[k]; in_last = 1'b0;
      acc = (in_ready === 1'b1);
      step();
      if (acc) begin model_accept(ops[k], pls[k], 1'b0); k++; end
    end
    in_valid = 1'b0;
    total_cnt++; if (k != 2) $display("FAIL full_accepted: got %0d want 2", k); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (got_q.size() != 0) $display("FAIL full_no_write: got %0d want 0", got_q.size()); else pass_cnt++;
    fifo_data_count = 32'd15;
    repeat (6) step();
    total_cnt++; if (got_q.size() != 1) $display("FAIL full_one_slot: got %0d want 1", got_q.size()); else pass_cnt++;
    send_word(ops[2], pls[2], 1'b0);
    fifo_data_count = 32'd14;
    repeat (6) step();
    total_cnt++; if (got_q.size() != 3) $display("FAIL full_two_slots: got %0d want 3", got_q.size()); else pass_cnt++;
    total_cnt++; if (fifo_data_count !== 32'd16) $display("FAIL full_occupancy: got %0d want 16", fifo_data_count); else pass_cnt++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL full_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    drain_mode = 1;
    wait_idle();
    total_cnt++; if (timeouts != 0) $display("FAIL full_timeout: got %0d want 0", timeouts); else pass_cnt++;
  endtask

  task automatic test_abort();
    clear_sb();
    drain_mode = 0;
    fifo_data_count = 32'd16;
    send_word(8'h11, $urandom, 1'b0);
    send_word(8'h22, $urandom, 1'b1);
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_staged_busy: got %b want 1", busy); else pass_cnt++;
    in_valid = 1'b1; in_opcode = 8'h33; in_payload = $urandom; in_last = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL abort_ready_low: got %b want 0", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_ready_back: got %b want 1", in_ready); else pass_cnt++;
    fifo_data_count = 32'd0;
    drain_mode = 1;
    repeat (10) step();
    total_cnt++; if (got_q.size() != 0) $display("FAIL abort_writes: got %0d want 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (words_written - ww0 !== 32'd0) $display("FAIL abort_ww: got %0d want 0", words_written - ww0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] op;
    clear_sb();
    drain_mode = 0;
    fifo_data_count = 32'd15;
    op = 8'($urandom_range(0, 254));
    if (op == END_OP) op = 8'h00;
    send_word(op, $urandom, 1'b1);
    repeat (4) step();
    total_cnt++; if (got_q.size() != 1) $display("FAIL rstmid_word_out: got %0d want 1", got_q.size()); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_marker_owed: got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    repeat (2) step();
    fifo_data_count = 32'd0;
    drain_mode = 1;
    step();
    total_cnt++;
    if ({in_ready, fifo_write, program_done, busy} !== 4'b0000)
      $display("FAIL rstmid_flags: got %b want 0000", {in_ready, fifo_write, program_done, busy});
    else pass_cnt++;
    total_cnt++; if (fifo_write_data !== 40'h0) $display("FAIL rstmid_data: got %h want 0", fifo_write_data); else pass_cnt++;
    total_cnt++; if (words_written !== 32'd0) $display("FAIL rstmid_ww: got %0d want 0", words_written); else pass_cnt++;
    rst = 1'b0;
    repeat (10) step();
    total_cnt++; if (got_q.size() != 1) $display("FAIL rstmid_no_marker: got %0d want 1", got_q.size()); else pass_cnt++;
    total_cnt++; if (words_written !== 32'd0) $display("FAIL rstmid_ww_after: got %0d want 0", words_written); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    clear_sb();
    drain_mode = 1;
    fifo_data_count = 32'd0;
    for (int i = 0; i < 100; i++) send_word(8'($urandom_range(0, 255)), $urandom, 1'b0);
    wait_idle();
    n = got_q.size();
    total_cnt++; if (timeouts != 0) $display("FAIL stream_timeout: got %0d want 0", timeouts); else pass_cnt++;
    total_cnt++; if (n != 100) $display("FAIL stream_count: got %0d want 100", n); else pass_cnt++;
    foreach (exp_q[i]) if (i < n) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL stream_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    if (n == 100) begin
      total_cnt++; if (got_cyc[99] - got_cyc[0] != 99) $display("FAIL stream_rate: got span %0d want 99", got_cyc[99] - got_cyc[0]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 0) $display("FAIL stream_done: got %0d want 0", done_cnt); else pass_cnt++;
    total_cnt++; if (words_written - ww0 !== 32'd100) $display("FAIL stream_ww: got %0d want 100", words_written - ww0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_program();
    test_random_programs();
    test_fifo_full();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/buf_writer.md
BUF_WRITER -- requirements
Module: buf_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: capacity, in 40-bit words, of the downstream command FIFO.
REQ-002 SHALL have parameter END_OPCODE, default 8'hBF: opcode of the program end marker.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: host command word present.
REQ-006 SHALL have port in_ready, output, 1: block accepts the word this cycle.
REQ-007 SHALL have port in_opcode, input, 8: command opcode; becomes bits [39:32].
REQ-008 SHALL have port in_payload, input, 32: command argument; becomes bits [31:0].
REQ-009 SHALL have port in_last, input, 1: word is the final word of a program.
REQ-010 SHALL have port abort, input, 1: discard all staged words.
REQ-011 SHALL have port fifo_write, output, 1: write strobe to the FIFO.
REQ-012 SHALL have port fifo_write_data, output, 40: word to the FIFO.
REQ-013 SHALL have port fifo_data_count, input, 32: FIFO occupancy; updates the cycle after a sampled write.
REQ-014 SHALL have port busy, output, 1: a staged word or end-marker emission is pending.
REQ-015 SHALL have port program_done, output, 1: one-cycle pulse when a program's last FIFO word is written.
REQ-016 SHALL have port words_written, output, 32: total FIFO writes since reset; wraps modulo 2^32.

Function
REQ-017 SHALL stage accepted words in a 2-entry in-order queue, each entry holding {opcode, payload, last}.
REQ-018 SHALL drive in_ready from registered state only, high exactly when the queue holds fewer than 2 entries and no end marker is pending.
REQ-019 SHALL accept a word on a cycle where in_valid and in_ready are both high.
REQ-020 SHALL compute free = FIFO_DEPTH - fifo_data_count - fifo_write, using the current registered fifo_write.
REQ-021 SHALL register fifo_write and fifo_write_data; it writes on the next edge only when free > 0 and a word is available.
REQ-022 SHALL give a word accepted into an empty queue its earliest fifo_write on the second cycle after acceptance.
REQ-023 SHALL implement the states IDLE, STREAM and EMIT_END.
REQ-024 SHALL move IDLE -> STREAM on acceptance, and STREAM -> IDLE when the queue empties and no end marker is owed.
REQ-025 SHALL enter EMIT_END when a last-flagged word whose opcode is not END_OPCODE is written; it then writes {END_OPCODE, 32'h0} as soon as free > 0 and returns to IDLE or STREAM.
REQ-026 SHALL write no further marker for a last-flagged word whose opcode equals END_OPCODE.
REQ-027 SHALL raise program_done for one cycle, coincident with fifo_write of the program's final FIFO word (the marker or the END_OPCODE word).
REQ-028 SHALL increment words_written by 1 for every cycle in which fifo_write is high.
REQ-029 SHALL handle abort as follows: queue cleared, EMIT_END cancelled, next state IDLE, fifo_write low the next cycle, in_ready low the next cycle.
REQ-030 SHALL give abort priority over a simultaneous acceptance; the word is dropped.
REQ-031 SHALL permit accept and dequeue in the same cycle; queue occupancy is then unchanged and ordering is preserved.
REQ-032 SHALL never write when fifo_data_count >= FIFO_DEPTH, regardless of queue contents.
REQ-033 SHALL be high on busy exactly when the queue is non-empty or the state is EMIT_END.

Reset
REQ-034 SHALL, while rst is high, clear the queue and force state IDLE.
REQ-035 SHALL, while rst is high, hold in_ready, fifo_write, program_done and busy at 0.
REQ-036 SHALL, while rst is high, hold fifo_write_data at 40'h0 and words_written at 0.
REQ-037 SHALL discard any in-flight program on reset mid-operation, with no marker written afterward.
REQ-038 SHALL raise in_ready the first cycle after rst falls.

Verification
REQ-039 SHALL pass this bench: single word {80, 00000000} with last=1 -> FIFO receives 40'h8000000000 then 40'hBF00000000 on consecutive cycles; program_done pulses with the second; words_written=2.
REQ-040 SHALL pass this bench: program 8000000000, 4000000000, 8300000001, BF00000000 (last) -> four FIFO writes in order, no extra marker, program_done once, words_written=4.
REQ-041 SHALL pass this bench: FIFO held at count 16, 3 words offered -> in_ready drops after 2 accepted; no fifo_write; after drain to 15, exactly one write per free slot.
REQ-042 SHALL pass this bench: abort asserted with 2 staged words and in_valid high -> zero further writes, busy=0 and in_ready=0 next cycle, in_ready=1 the cycle after.
REQ-043 SHALL pass this bench: rst asserted in EMIT_END -> no marker written; all outputs 0 while rst is high; words_written=0.
REQ-044 SHALL pass this bench: continuous in_valid with the FIFO drained one word per cycle -> sustained one write per cycle, order preserved, no drop or duplicate across 100 words.
